// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI frame sequencer + byte memory (rx_data/rx_valid in; tx_data/tx_valid, busy, err out)
module spi_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int MEM_DEPTH = 256,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              err
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [7:0] mem [MEM_DEPTH];
  logic [1:0] cmd_q;
  logic [ADDR_W-1:0] pay_q;
  logic [AW-1:0] wr_addr, rd_addr;
  logic wr_ok, rd_ok, rxv_q, accept, range_ok, exec;
  assign accept = rx_valid & ~rxv_q;
  assign range_ok = (pay_q >> AW) == '0;
  assign exec = state == EXEC;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (accept ? EXEC : IDLE) :
              (exec && cmd_q == 2'b11 && rd_ok) ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rxv_q <= 1'b1;
      cmd_q <= '0;
      pay_q <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      wr_ok <= 1'b0;
      rd_ok <= 1'b0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      rxv_q <= rx_valid;
      tx_valid <= 1'b0;
      err <= accept & busy;
      if (state == IDLE && accept) {pay_q, cmd_q} <= rx_data;
      if (exec)
        case (cmd_q)
          2'b00: if (range_ok) begin
            wr_addr <= pay_q[AW-1:0];
            wr_ok <= 1'b1;
          end else err <= 1'b1;
          2'b01: if (wr_ok) begin
            if (AUTO_INC) wr_addr <= wr_addr + AW'(1);
          end else err <= 1'b1;
          2'b10: if (range_ok) begin
            rd_addr <= pay_q[AW-1:0];
            rd_ok <= 1'b1;
          end else err <= 1'b1;
          default: if (rd_ok) begin
            tx_data <= mem[rd_addr];
            tx_valid <= 1'b1;
            if (AUTO_INC) rd_addr <= rd_addr + AW'(1);
          end else err <= 1'b1;
        endcase
    end
  always_ff @(posedge clk)
    if (exec && cmd_q == 2'b01 && wr_ok) mem[wr_addr] <= pay_q[7:0];
endmodule
